// File: rtl/div_iter_param_if.sv
// div_iter_param_if: operand/result bundle between control unit and divider.
// Carries div_ovf only when DIV_ITER_OVERFLOW_EN is defined.
interface div_iter_param_if #(
   parameter int WIDTH = 32
);
   logic             div_control;
   logic             div_signed;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_busy;
   logic             div_stop;
   logic             div_zero;
`ifdef DIV_ITER_OVERFLOW_EN
   logic             div_ovf;

   modport master (
      output div_control, div_signed, A, B,
      input  hi, lo, div_busy, div_stop, div_zero, div_ovf
   );
   modport slave (
      input  div_control, div_signed, A, B,
      output hi, lo, div_busy, div_stop, div_zero, div_ovf
   );
`else
   modport master (
      output div_control, div_signed, A, B,
      input  hi, lo, div_busy, div_stop, div_zero
   );
   modport slave (
      input  div_control, div_signed, A, B,
      output hi, lo, div_busy, div_stop, div_zero
   );
`endif
endinterface

// File: rtl/div_iter_param.sv
// div_iter_param: restoring divider (DIV/DIVU), one quotient bit per clock.
// lo = quotient, hi = remainder; DIV_ITER_OVERFLOW_EN adds div_ovf.
module div_iter_param #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic             clk,
   input logic             reset,
   div_iter_param_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, state_n;
   logic [WIDTH-1:0] dvd, dvd_n;
   logic [WIDTH-1:0] dvs, dvs_n;
   logic [WIDTH-1:0] quo, quo_n;
   logic [WIDTH-1:0] rem, rem_n;
   logic [WIDTH-1:0] hi, hi_n;
   logic [WIDTH-1:0] lo, lo_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH:0]   trial;
   logic [IDX_W-1:0] idx;
   logic             q_neg, q_neg_n;
   logic             r_neg, r_neg_n;
   logic             busy, busy_n;
   logic             stop, stop_n;
   logic             zero, zero_n;
   logic             a_neg, b_neg;
`ifdef DIV_ITER_OVERFLOW_EN
   logic             ovf_p, ovf_p_n;
   logic             ovf, ovf_n;
`endif

   always_comb begin
      state_n = state;
      dvd_n   = dvd;
      dvs_n   = dvs;
      quo_n   = quo;
      rem_n   = rem;
      hi_n    = hi;
      lo_n    = lo;
      cnt_n   = cnt;
      q_neg_n = q_neg;
      r_neg_n = r_neg;
      busy_n  = busy;
      stop_n  = 1'b0;
      zero_n  = 1'b0;
`ifdef DIV_ITER_OVERFLOW_EN
      ovf_p_n = ovf_p;
      ovf_n   = 1'b0;
`endif
      a_neg = bus.div_signed & bus.A[WIDTH-1];
      b_neg = bus.div_signed & bus.B[WIDTH-1];
      idx   = cnt[IDX_W-1:0];
      // 33-bit shift-in so unsigned compares never overflow
      trial = {rem, dvd[idx]};
      unique case (state)
         IDLE: begin
            if (bus.div_control) begin
               if (bus.B == '0) begin
                  stop_n = 1'b1;
                  zero_n = 1'b1;
               end else begin
                  dvd_n   = a_neg ? -bus.A : bus.A;
                  dvs_n   = b_neg ? -bus.B : bus.B;
                  q_neg_n = a_neg ^ b_neg;
                  r_neg_n = a_neg;
                  rem_n   = '0;
                  quo_n   = '0;
                  cnt_n   = CNT_W'(WIDTH - 1);
                  busy_n  = 1'b1;
                  state_n = CALC;
`ifdef DIV_ITER_OVERFLOW_EN
                  ovf_p_n = bus.div_signed
                          & (bus.A == MIN)
                          & (&bus.B);
`endif
               end
            end
         end
         CALC: begin
            if (trial >= {1'b0, dvs}) begin
               rem_n      = trial[WIDTH-1:0] - dvs;
               quo_n[idx] = 1'b1;
            end else begin
               rem_n = trial[WIDTH-1:0];
            end
            if (cnt == '0) state_n = FIX;
            else           cnt_n   = cnt - 1'b1;
         end
         FIX: begin
            lo_n    = q_neg ? -quo : quo;
            hi_n    = r_neg ? -rem : rem;
            busy_n  = 1'b0;
            stop_n  = 1'b1;
            state_n = IDLE;
`ifdef DIV_ITER_OVERFLOW_EN
            ovf_n   = ovf_p;
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         dvd   <= '0;
         dvs   <= '0;
         quo   <= '0;
         rem   <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         busy  <= 1'b0;
         stop  <= 1'b0;
         zero  <= 1'b0;
`ifdef DIV_ITER_OVERFLOW_EN
         ovf_p <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         dvd   <= dvd_n;
         dvs   <= dvs_n;
         quo   <= quo_n;
         rem   <= rem_n;
         hi    <= hi_n;
         lo    <= lo_n;
         cnt   <= cnt_n;
         q_neg <= q_neg_n;
         r_neg <= r_neg_n;
         busy  <= busy_n;
         stop  <= stop_n;
         zero  <= zero_n;
`ifdef DIV_ITER_OVERFLOW_EN
         ovf_p <= ovf_p_n;
         ovf   <= ovf_n;
`endif
      end
   end

   assign bus.hi       = hi;
   assign bus.lo       = lo;
   assign bus.div_busy = busy;
   assign bus.div_stop = stop;
   assign bus.div_zero = zero;
`ifdef DIV_ITER_OVERFLOW_EN
   assign bus.div_ovf  = ovf;
`endif

endmodule
